io_uart: RTL
============

# io_uart

Memory-mapped 8N1 UART peripheral on the CPU I/O bus: decodes the core's `io_read_enable`/`io_write_enable`/`io_address`/`io_write_data` strobes and returns `io_read_data` in the same cycle. Sits directly downstream of the CPU's SYS instruction path. It provides a transmit FIFO, a single-byte receive buffer, a status register and a programmable bit divisor.

## Interface
Parameters:
- `BASE_ADDR`, 16'h0000: base of the 3-register window (4-byte-aligned).
- `CLKS_PER_BIT`, 16'd104: reset value of the divisor.
- `TX_DEPTH`, 4: TX FIFO entries (power of 2, 2..16).

Ports:
- `clk`  in  1  clock, rising edge.
- `resetq`  in  1  asynchronous, active-low reset.
- `io_read_enable`  in  1  read strobe, one cycle per access.
- `io_write_enable`  in  1  write strobe, one cycle per access.
- `io_address`  in  16  byte address; bits [1:0] always 0.
- `io_write_data`  in  16  write data.
- `io_read_data`  out  16  read data, combinational from address.
- `uart_tx`  out  1  serial out, idle high.
- `uart_rx`  in  1  serial in, asynchronous.

## Operation
- Register map, offsets from `BASE_ADDR`. Any other address reads 0; writes to it are ignored.
  - `+0` DATA
    - Write: push `io_write_data` LSB byte into the TX FIFO.
    - Read: returns {8'h00, rx_byte}. If rx_valid=1, clears rx_valid on the edge.
  - `+4` STATUS (read-only)
    - Bit 0: tx_full. Bit 1: tx_idle (FIFO empty and shifter idle). Bit 2: rx_valid. Bit 3: rx_overrun. Bit 4: rx_frame_err. Other bits are 0.
    - A read clears bits 3 and 4 on the edge.
  - `+8` DIV
    - Read/write, 16 bits: clocks per bit. The value 0 behaves as 1.
- `io_read_data` is combinational so the core samples it in the strobe cycle. Side effects (pop, flag clear) occur on the rising edge that ends the strobe cycle, only when `io_read_enable`=1.
- Read and write enabled in the same cycle: both are performed. A read of DATA returns the pre-edge value.
- TX FIFO:
  - A push while full is dropped; FIFO contents are unchanged.
  - Push and pop in the same edge are both honoured.
  - Pointers wrap modulo `TX_DEPTH`.
- TX FSM states: IDLE, START, DATA (8 bits, LSB first), STOP.
  - IDLE→START when the FIFO is non-empty; the byte is popped on that edge.
  - Each state holds for DIV clocks.
  - STOP→START directly if the FIFO is non-empty, otherwise STOP→IDLE.
  - The DIV value is latched at the start of each bit. A DIV write mid-bit affects the next bit.
- RX FSM states: IDLE, START, DATA, STOP.
  - `uart_rx` passes through a 2-flop synchronizer, reset to 1.
  - IDLE→START on a synchronized falling edge.
  - The start bit is re-checked after DIV/2 (floor, min 1) clocks. If high, return to IDLE with no flag.
  - 8 data bits are sampled at DIV-clock intervals, then the stop bit.
  - Stop bit = 0: set rx_frame_err and discard the byte.
  - Stop bit = 1 and rx_valid=0: store the byte and set rx_valid.
  - Stop bit = 1 and rx_valid=1: set rx_overrun and drop the new byte. Exception: if a DATA read occurs on the same edge, no overrun is set and the new byte is stored.
- Reset values:
  - `uart_tx`=1, `io_read_data`=0 (strobes low).
  - FIFO empty, both FSMs IDLE, DIV=`CLKS_PER_BIT`, all flags 0, rx_byte=0.
- Reset asserted mid-frame aborts immediately: `uart_tx` returns to 1 asynchronously and all state is lost.

## Timing
- Write latency: push on edge k, then `uart_tx` falls after edge k+1 (shifter idle).
- Frame length: exactly 10×DIV clocks. Back-to-back frames have zero idle gap.
- rx_valid rises on the edge after the mid-stop-bit sample. It lags the true stop-bit centre by 2–3 clocks (synchronizer).
- Status reflects state as of the previous edge; no same-cycle bypass.

## Configuration
- `IO_UART_RX_EN` defined: RX path, synchronizer, rx_byte and STATUS bits 2–4 present as described.
- Not defined: RX logic is removed and `uart_rx` is ignored. DATA reads return 0; STATUS bits 2–4 read 0. TX and DIV are unchanged.

## Test plan
- Reset, DIV=4, write DATA=16'h00A5 → `uart_tx` sequence 0,1,0,1,0,0,1,0,1,1, each 4 clocks; STATUS bit 1 returns to 1 after 40 clocks.
- DIV=2, 5 writes back-to-back with `TX_DEPTH`=4 → STATUS bit 0 set after the 4th unpopped push. 5th byte dropped if the FIFO is still full. Serial output is continuous frames with no gap.
- DIV=8, drive 8'h3C on `uart_rx` → STATUS=16'h0006; DATA read returns 16'h003C; next STATUS=16'h0002.
- Two bytes received without a read → STATUS bit 3 set, DATA holds the first byte; STATUS read → bit 3 cleared.
- Frame with stop bit 0 → bit 4 set, rx_valid stays 0. 2-clock low glitch at DIV=8 → no flag, no byte.
- Assert `resetq`=0 mid-TX-frame → `uart_tx`=1 immediately, DIV reads `CLKS_PER_BIT`, STATUS reads 16'h0002.

Source files
------------

// File: rtl/io_uart.sv
// io_uart: memory-mapped 8N1 UART with a TX FIFO, single-byte RX buffer, status and divisor registers.
// Build option IO_UART_RX_EN: when defined the receive path exists; otherwise uart_rx is ignored.
module io_uart #(
  parameter logic [15:0] BASE_ADDR    = 16'h0000,
  parameter logic [15:0] CLKS_PER_BIT = 16'd104,
  parameter int          TX_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic        io_read_enable,
  input  logic        io_write_enable,
  input  logic [15:0] io_address,
  input  logic [15:0] io_write_data,
  output logic [15:0] io_read_data,
  output logic        uart_tx,
  input  logic        uart_rx
);
  localparam int AW = (TX_DEPTH > 2) ? $clog2(TX_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(TX_DEPTH);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_START = 2'd1, S_DATA = 2'd2, S_STOP = 2'd3} state_e;

  logic sel_data_s, sel_stat_s, sel_div_s;
  assign sel_data_s = (io_address == BASE_ADDR);
  assign sel_stat_s = (io_address == BASE_ADDR + 16'd4);
  assign sel_div_s  = (io_address == BASE_ADDR + 16'd8);

  logic [15:0] div_q, div_eff_s, bit_len_s;
  assign div_eff_s = (div_q == 16'd0) ? 16'd1 : div_q;
  assign bit_len_s = div_eff_s - 16'd1;

  // Divisor register
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) div_q <= CLKS_PER_BIT;
    else if (io_write_enable && sel_div_s) div_q <= io_write_data;
    else div_q <= div_q;
  end

  logic [7:0]    fifo_q [TX_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          full_s, empty_s, push_s, pop_s;
  assign full_s  = (count_q == DEPTH_C);
  assign empty_s = (count_q == {(AW+1){1'b0}});
  assign push_s  = io_write_enable && sel_data_s && !full_s;

  // TX FIFO storage and pointers
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      for (int i = 0; i < TX_DEPTH; i++) fifo_q[i] <= 8'h00;
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
    end else begin
      if (push_s) begin
        fifo_q[wr_ptr_q] <= io_write_data[7:0];
        wr_ptr_q         <= wr_ptr_q + AW'(1'b1);
      end
      if (pop_s) rd_ptr_q <= rd_ptr_q + AW'(1'b1);
      count_q <= count_q + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, pop_s};
    end
  end

  state_e      tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic        tx_q, tx_d, tx_done_s, tx_idle_s;
  assign tx_done_s = (tx_cnt_q == 16'd0);
  assign tx_idle_s = empty_s && (tx_state_q == S_IDLE);
  assign uart_tx   = tx_q;

  // TX state register; line output resets high asynchronously
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= 16'd0;
      tx_shift_q <= 8'h00;
      tx_bit_q   <= 3'd0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_shift_q <= tx_shift_d;
      tx_bit_q   <= tx_bit_d;
      tx_q       <= tx_d;
    end
  end

  // TX next state: each bit reloads the counter from the current divisor
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_shift_d = tx_shift_q;
    tx_bit_d   = tx_bit_q;
    pop_s      = 1'b0;
    case (tx_state_q)
      S_IDLE: begin
        if (!empty_s) begin
          tx_state_d = S_START;
          tx_cnt_d   = bit_len_s;
          tx_shift_d = fifo_q[rd_ptr_q];
          pop_s      = 1'b1;
        end else tx_state_d = S_IDLE;
      end
      S_START: begin
        if (tx_done_s) begin
          tx_state_d = S_DATA;
          tx_cnt_d   = bit_len_s;
          tx_bit_d   = 3'd0;
        end else tx_cnt_d = tx_cnt_q - 16'd1;
      end
      S_DATA: begin
        if (tx_done_s) begin
          tx_cnt_d = bit_len_s;
          if (tx_bit_q == 3'd7) tx_state_d = S_STOP;
          else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
          end
        end else tx_cnt_d = tx_cnt_q - 16'd1;
      end
      S_STOP: begin
        if (tx_done_s && !empty_s) begin
          tx_state_d = S_START;
          tx_cnt_d   = bit_len_s;
          tx_shift_d = fifo_q[rd_ptr_q];
          pop_s      = 1'b1;
        end else if (tx_done_s) tx_state_d = S_IDLE;
        else tx_cnt_d = tx_cnt_q - 16'd1;
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  // TX line value for the next state
  always_comb begin
    case (tx_state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = tx_shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  logic [7:0] rx_byte_s;
  logic       rx_valid_s, rx_ovr_flag_s, rx_ferr_flag_s;

`ifdef IO_UART_RX_EN
  logic [2:0]  rx_sync_q;
  logic        rx_s, rx_fall_s, rx_done_s, rd_data_s, rd_stat_s;
  state_e      rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d, rx_half_s;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d, rx_byte_q;
  logic        rx_valid_q, rx_ovr_q, rx_ferr_q;
  logic        rx_stop_smp_s, rx_store_s, rx_ovr_set_s, rx_ferr_set_s;

  assign rx_s      = rx_sync_q[1];
  assign rx_fall_s = rx_sync_q[2] && !rx_sync_q[1];
  assign rx_done_s = (rx_cnt_q == 16'd0);
  assign rx_half_s = (div_eff_s < 16'd2) ? 16'd1 : {1'b0, div_eff_s[15:1]};
  assign rd_data_s = io_read_enable && sel_data_s;
  assign rd_stat_s = io_read_enable && sel_stat_s;

  // RX synchronizer plus one delay stage for edge detection
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) rx_sync_q <= 3'b111;
    else rx_sync_q <= {rx_sync_q[1:0], uart_rx};
  end

  // RX state register
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= 16'd0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'h00;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  // RX next state: start bit re-checked at half a bit, then samples at bit centres
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    case (rx_state_q)
      S_IDLE: begin
        if (rx_fall_s) begin
          rx_state_d = S_START;
          rx_cnt_d   = rx_half_s - 16'd1;
        end else rx_state_d = S_IDLE;
      end
      S_START: begin
        if (rx_done_s && !rx_s) begin
          rx_state_d = S_DATA;
          rx_cnt_d   = bit_len_s;
          rx_bit_d   = 3'd0;
        end else if (rx_done_s) rx_state_d = S_IDLE;
        else rx_cnt_d = rx_cnt_q - 16'd1;
      end
      S_DATA: begin
        if (rx_done_s) begin
          rx_shift_d = {rx_s, rx_shift_q[7:1]};
          rx_cnt_d   = bit_len_s;
          if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
          else rx_bit_d = rx_bit_q + 3'd1;
        end else rx_cnt_d = rx_cnt_q - 16'd1;
      end
      S_STOP: begin
        if (rx_done_s) rx_state_d = S_IDLE;
        else rx_cnt_d = rx_cnt_q - 16'd1;
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  // RX outputs: stop-bit verdict; a same-edge DATA read frees the buffer
  always_comb begin
    rx_stop_smp_s = (rx_state_q == S_STOP) && rx_done_s;
    rx_store_s    = rx_stop_smp_s && rx_s && (!rx_valid_q || rd_data_s);
    rx_ovr_set_s  = rx_stop_smp_s && rx_s && rx_valid_q && !rd_data_s;
    rx_ferr_set_s = rx_stop_smp_s && !rx_s;
  end

  // RX buffer and sticky flags
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rx_byte_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      if (rx_store_s) rx_byte_q <= rx_shift_q;
      if (rx_store_s) rx_valid_q <= 1'b1;
      else if (rd_data_s) rx_valid_q <= 1'b0;
      if (rx_ovr_set_s) rx_ovr_q <= 1'b1;
      else if (rd_stat_s) rx_ovr_q <= 1'b0;
      if (rx_ferr_set_s) rx_ferr_q <= 1'b1;
      else if (rd_stat_s) rx_ferr_q <= 1'b0;
    end
  end

  assign rx_byte_s      = rx_byte_q;
  assign rx_valid_s     = rx_valid_q;
  assign rx_ovr_flag_s  = rx_ovr_q;
  assign rx_ferr_flag_s = rx_ferr_q;
`else
  logic unused_rx_s;
  assign unused_rx_s    = uart_rx;
  assign rx_byte_s      = 8'h00;
  assign rx_valid_s     = 1'b0;
  assign rx_ovr_flag_s  = 1'b0;
  assign rx_ferr_flag_s = 1'b0;
`endif

  // Read mux, valid only during a read strobe
  always_comb begin
    io_read_data = 16'h0000;
    if (io_read_enable && sel_data_s) io_read_data = {8'h00, rx_byte_s};
    else if (io_read_enable && sel_stat_s)
      io_read_data = {11'd0, rx_ferr_flag_s, rx_ovr_flag_s, rx_valid_s, tx_idle_s, full_s};
    else if (io_read_enable && sel_div_s) io_read_data = div_q;
    else io_read_data = 16'h0000;
  end
endmodule
